// File: rtl/mips_fu_sequencer_if.sv
// mips_fu_sequencer_if
// Bundles every signal between the sequencer and its surroundings: the two
// requesters, the combinational function unit and the response consumer.
//   slave  : the sequencer's view. It receives requests and function-unit
//            results, and drives the grants, the function-unit inputs,
//            the response and the architectural flags.
//   master : the environment's view (requesters, function unit, consumer).
// Clock and reset are not part of the bundle. They stay plain module ports.
interface mips_fu_sequencer_if;

   // Requester 0
   logic        req0_valid;
   logic        req0_ready;
   logic [4:0]  req0_op;
   logic [31:0] req0_a;
   logic [31:0] req0_b;
   logic [4:0]  req0_shift;
   logic        req0_use_c;
   logic        req0_set_flags;

   // Requester 1
   logic        req1_valid;
   logic        req1_ready;
   logic [4:0]  req1_op;
   logic [31:0] req1_a;
   logic [31:0] req1_b;
   logic [4:0]  req1_shift;
   logic        req1_use_c;
   logic        req1_set_flags;

   // Function-unit drive and combinational result
   logic [4:0]  fu_func_sel;
   logic [31:0] fu_in_a;
   logic [31:0] fu_in_b;
   logic [4:0]  fu_shift;
   logic        fu_c_in;
   logic [31:0] fu_out;
   logic        fu_z;
   logic        fu_n;
   logic        fu_c;
   logic        fu_v;

   // Response channel and architectural flags {N,Z,C,V}
   logic        rsp_valid;
   logic        rsp_ready;
   logic        rsp_id;
   logic [31:0] rsp_data;
   logic [3:0]  rsp_flags;
   logic [3:0]  status_flags;

   modport slave (
      input  req0_valid, req0_op, req0_a, req0_b, req0_shift, req0_use_c, req0_set_flags,
      output req0_ready,
      input  req1_valid, req1_op, req1_a, req1_b, req1_shift, req1_use_c, req1_set_flags,
      output req1_ready,
      output fu_func_sel, fu_in_a, fu_in_b, fu_shift, fu_c_in,
      input  fu_out, fu_z, fu_n, fu_c, fu_v,
      output rsp_valid, rsp_id, rsp_data, rsp_flags, status_flags,
      input  rsp_ready
   );

   modport master (
      output req0_valid, req0_op, req0_a, req0_b, req0_shift, req0_use_c, req0_set_flags,
      input  req0_ready,
      output req1_valid, req1_op, req1_a, req1_b, req1_shift, req1_use_c, req1_set_flags,
      input  req1_ready,
      input  fu_func_sel, fu_in_a, fu_in_b, fu_shift, fu_c_in,
      output fu_out, fu_z, fu_n, fu_c, fu_v,
      input  rsp_valid, rsp_id, rsp_data, rsp_flags, status_flags,
      output rsp_ready
   );

endinterface

// File: rtl/mips_fu_sequencer.sv
// mips_fu_sequencer
// Arbitrates between two requesters and sends one operation at a time
// through an external combinational function unit. It returns the result
// and the flags on a response channel. It can also update the
// architectural {N,Z,C,V} flag register.
// Ports:
//   clk   : rising-edge clock for all state
//   rst_n : asynchronous active-low reset
//   bus   : mips_fu_sequencer_if.slave. It carries the requester
//           handshakes, the function-unit drive and result, the response
//           channel and status_flags.
// Parameter:
//   RR_EN : 1 selects round-robin arbitration.
//           0 selects fixed priority, where requester 0 wins.
module mips_fu_sequencer #(
   parameter int unsigned RR_EN = 1
) (
   input logic              clk,
   input logic              rst_n,
   mips_fu_sequencer_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t      state_q;
   logic        ptr_q;
   logic        setFlags_q;
   logic        id_q;
   logic [4:0]  fuFuncSel_q;
   logic [31:0] fuInA_q;
   logic [31:0] fuInB_q;
   logic [4:0]  fuShift_q;
   logic        fuCIn_q;
   logic        rspValid_q;
   logic        rspId_q;
   logic [31:0] rspData_q;
   logic [3:0]  rspFlags_q;
   logic [3:0]  statusFlags_q;

   logic        grant0;
   logic        grant1;
   logic        accept;
   logic [4:0]  selOp;
   logic [31:0] selA;
   logic [31:0] selB;
   logic [4:0]  selShift;
   logic        selUseC;
   logic        selSetFlags;
   logic        fuCIn_d;
   logic [3:0]  resFlags_d;

   // Grant selection. A contested cycle goes to the pointed requester in
   // round-robin mode, and always to requester 0 in fixed-priority mode.
   // An uncontested requester simply wins.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (bus.req0_valid && bus.req1_valid) begin
         if (RR_EN != 0) begin
            grant0 = ~ptr_q;
            grant1 = ptr_q;
         end else begin
            grant0 = 1'b1;
         end
      end else begin
         grant0 = bus.req0_valid;
         grant1 = bus.req1_valid;
      end
   end

   // Fields of the winning requester. A carry-in is taken from the flag
   // register only when the op asks for it. Reading the current register
   // value at acceptance is enough for back-to-back chaining, because the
   // previous op wrote its flags before this one could be accepted.
   always_comb begin
      selOp       = grant1 ? bus.req1_op        : bus.req0_op;
      selA        = grant1 ? bus.req1_a         : bus.req0_a;
      selB        = grant1 ? bus.req1_b         : bus.req0_b;
      selShift    = grant1 ? bus.req1_shift     : bus.req0_shift;
      selUseC     = grant1 ? bus.req1_use_c     : bus.req0_use_c;
      selSetFlags = grant1 ? bus.req1_set_flags : bus.req0_set_flags;
      fuCIn_d     = selUseC & statusFlags_q[1];
      resFlags_d  = {bus.fu_n, bus.fu_z, bus.fu_c, bus.fu_v};
   end

   assign accept = (state_q == IDLE) && (grant0 || grant1);

   // The ready signals are combinational, because the grant must answer
   // the valid in the same cycle. They are gated by rst_n so that no
   // handshake completes while the block is held in reset.
   assign bus.req0_ready = rst_n && (state_q == IDLE) && grant0;
   assign bus.req1_ready = rst_n && (state_q == IDLE) && grant1;

   // Main sequencer. The function-unit inputs are loaded at acceptance,
   // so they are already valid during the single EXEC cycle. The
   // function select returns to 0 when EXEC ends. The operands and the
   // carry-in keep their last values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         ptr_q         <= 1'b0;
         setFlags_q    <= 1'b0;
         id_q          <= 1'b0;
         fuFuncSel_q   <= 5'd0;
         fuInA_q       <= 32'd0;
         fuInB_q       <= 32'd0;
         fuShift_q     <= 5'd0;
         fuCIn_q       <= 1'b0;
         rspValid_q    <= 1'b0;
         rspId_q       <= 1'b0;
         rspData_q     <= 32'd0;
         rspFlags_q    <= 4'd0;
         statusFlags_q <= 4'd0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  fuFuncSel_q <= selOp;
                  fuInA_q     <= selA;
                  fuInB_q     <= selB;
                  fuShift_q   <= selShift;
                  fuCIn_q     <= fuCIn_d;
                  setFlags_q  <= selSetFlags;
                  id_q        <= grant1;
                  ptr_q       <= grant0;
                  state_q     <= EXEC;
               end
            end
            EXEC: begin
               rspData_q   <= bus.fu_out;
               rspFlags_q  <= resFlags_d;
               rspId_q     <= id_q;
               rspValid_q  <= 1'b1;
               fuFuncSel_q <= 5'd0;
               if (setFlags_q) begin
                  statusFlags_q <= resFlags_d;
               end
               state_q <= RESP;
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  rspValid_q <= 1'b0;
                  state_q    <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.fu_func_sel  = fuFuncSel_q;
   assign bus.fu_in_a      = fuInA_q;
   assign bus.fu_in_b      = fuInB_q;
   assign bus.fu_shift     = fuShift_q;
   assign bus.fu_c_in      = fuCIn_q;
   assign bus.rsp_valid    = rspValid_q;
   assign bus.rsp_id       = rspId_q;
   assign bus.rsp_data     = rspData_q;
   assign bus.rsp_flags    = rspFlags_q;
   assign bus.status_flags = statusFlags_q;

endmodule
